// File: rtl/tpg3_nand3_bist.sv
// ============================================================================
// Module   : tpg3_nand3_bist
// Purpose  : Exhaustive 3-input NAND self-test: drives all eight input vectors,
//            compares ZN against the ideal response and reports the result.
//            Optional 16-bit response MISR enabled by GF180MCU_FD_SC_MCU9T5V0__TPG3_SIG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpg3_nand3_bist #(
  parameter int LOOPS  = 1,
  parameter int SETTLE = 2
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        START,
  input  logic        ABORT,
  output logic        A1,
  output logic        A2,
  output logic        A3,
  input  logic        ZN,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  ERR_CNT,
`ifdef GF180MCU_FD_SC_MCU9T5V0__TPG3_SIG_EN
  output logic [15:0] SIG,
`endif
  output logic [2:0]  FIRST_FAIL
);

  localparam logic [3:0] C_SETTLE    = 4'(SETTLE);
  localparam logic [7:0] C_LAST_LOOP = 8'(LOOPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_vec;
  logic [3:0]  r_timer;
  logic [7:0]  r_loop;
  logic [7:0]  r_err;
  logic [2:0]  r_first;
  logic        r_found;
  logic        r_done;
  logic        r_pass;

  logic        w_accept;
  logic        w_sample;
  logic        w_last;
  logic        w_miss;
  logic [7:0]  w_err_next;

  always_comb begin
    w_accept   = START && !ABORT && (r_state == ST_IDLE || r_state == ST_DONE);
    w_sample   = (r_state == ST_RUN) && (r_timer == C_SETTLE);
    w_last     = w_sample && (r_vec == 3'd7) && (r_loop == C_LAST_LOOP);
    w_miss     = w_sample && (ZN != ~(&r_vec));
    w_err_next = (w_miss && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (ABORT) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (START) w_state_next = ST_RUN;
        ST_RUN:           if (w_last) w_state_next = ST_DONE;
        default:          w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_vec   <= 3'd0;
      r_timer <= 4'd0;
      r_loop  <= 8'd0;
      r_err   <= 8'd0;
      r_first <= 3'd0;
      r_found <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (ABORT) begin
      // Error count and first-fail vector survive an abort for diagnosis.
      r_vec   <= 3'd0;
      r_timer <= 4'd0;
      r_loop  <= 8'd0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_vec   <= 3'd0;
      r_timer <= 4'd0;
      r_loop  <= 8'd0;
      r_err   <= 8'd0;
      r_first <= 3'd0;
      r_found <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_sample) begin
        r_err   <= w_err_next;
        r_timer <= 4'd0;
        if (w_miss && !r_found) begin
          r_first <= r_vec;
          r_found <= 1'b1;
        end
        // The final vector stays on the pins while DONE is shown.
        if (w_last) begin
          r_done <= 1'b1;
          r_pass <= (w_err_next == 8'd0);
        end else begin
          r_vec <= r_vec + 3'd1;
          if (r_vec == 3'd7) r_loop <= r_loop + 8'd1;
        end
      end else begin
        r_timer <= r_timer + 4'd1;
      end
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0__TPG3_SIG_EN
  logic [15:0] r_sig;
  logic        w_fb;

  always_comb begin
    w_fb = r_sig[15] ^ ZN;
  end

  // Galois form of x^16 + x^12 + x^5 + 1.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_sig <= 16'hFFFF;
    end else if (!ABORT && w_accept) begin
      r_sig <= 16'hFFFF;
    end else if (!ABORT && w_sample) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign SIG = r_sig;
`endif

  assign A1         = r_vec[0];
  assign A2         = r_vec[1];
  assign A3         = r_vec[2];
  assign DONE       = r_done;
  assign PASS       = r_pass;
  assign ERR_CNT    = r_err;
  assign FIRST_FAIL = r_first;

endmodule

`default_nettype wire

// File: doc/tpg3_nand3_bist.md
TPG3_NAND3_BIST -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__tpg3

Interface
REQ-001 SHALL have parameter LOOPS, default 1: number of full 8-vector passes per run (legal 1..255).
REQ-002 SHALL have parameter SETTLE, default 2: idle clocks between applying a vector and sampling ZN (legal 0..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port START  input  1  level; begins a run when sampled high in IDLE or DONE.
REQ-006 SHALL have port ABORT  input  1  level; terminates any run and returns to IDLE.
REQ-007 SHALL have ports A1, A2, A3  output  1 each  registered stimulus to the NAND3 under test.
REQ-008 SHALL have port ZN  input  1  response from the NAND3 under test.
REQ-009 SHALL have port DONE  output  1  high while in DONE state.
REQ-010 SHALL have port PASS  output  1  valid when DONE=1; high iff ERR_CNT=0.
REQ-011 SHALL have port ERR_CNT  output  8  saturating mismatch count for the current/last run.
REQ-012 SHALL have port FIRST_FAIL  output  3  vector {A3,A2,A1} of the first mismatch; 0 if none.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN or DONE->RUN on START=1 and ABORT=0; RUN->DONE after last sample; any state->IDLE on ABORT=1.
REQ-014 SHALL, on the edge that accepts START, clear ERR_CNT, FIRST_FAIL, PASS, DONE, set vector=0, timer=0, loop=0, drive {A3,A2,A1}=3'b000.
REQ-015 SHALL, in RUN, increment timer each edge; on the edge where timer==SETTLE, sample ZN, compare with ~(A1&A2&A3), reset timer to 0 and advance vector.
REQ-016 SHALL apply vectors in order 0..7 as {A3,A2,A1}; vector wraps 7->0 and increments loop.
REQ-017 SHALL give a per-vector period of SETTLE+1 clocks and a total run of 8*LOOPS*(SETTLE+1) clocks from the START-accept edge to the DONE-assert edge.
REQ-018 SHALL increment ERR_CNT on each mismatch, saturating at 255 with no wrap.
REQ-019 SHALL load FIRST_FAIL only on the first mismatch of a run; later mismatches leave it unchanged.
REQ-020 SHALL assert DONE and PASS on the edge after the final sample; PASS accounts for that final sample.
REQ-021 SHALL drive {A3,A2,A1}=3'b000 in IDLE and hold the last applied vector in DONE.
REQ-022 SHALL ignore START while in RUN.
REQ-023 SHALL give ABORT priority over START when both are high; ABORT clears DONE and PASS and preserves ERR_CNT and FIRST_FAIL.

Reset
REQ-024 SHALL, while RN=0, asynchronously force state=IDLE, A1=A2=A3=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, and SIG=16'hFFFF when present.
REQ-025 SHALL treat RN assertion mid-run as an immediate abort with no DONE pulse, and resume in IDLE on the first edge after RN deasserts.

Configuration
REQ-026 SHALL, with GF180MCU_FD_SC_MCU9T5V0__TPG3_SIG_EN defined, add output SIG[15:0]: a MISR seeded to 16'hFFFF at START-accept that shifts in each sampled ZN using polynomial x^16+x^12+x^5+1.
REQ-027 SHALL, with the macro undefined, omit the SIG port and MISR logic, leaving all other behaviour identical.

Verification
REQ-028 SHALL cover: LOOPS=1, SETTLE=2, ideal NAND3 model, START pulse -> DONE rises exactly 24 clocks after the accept edge, PASS=1, ERR_CNT=0, FIRST_FAIL=0.
REQ-029 SHALL cover: ZN stuck-at-1, LOOPS=2 -> ERR_CNT=2 (vector 7 each pass), FIRST_FAIL=3'b111, PASS=0.
REQ-030 SHALL cover: ZN stuck-at-0, LOOPS=255, SETTLE=0 -> ERR_CNT saturates at 255 (1785 mismatches), FIRST_FAIL=3'b000.
REQ-031 SHALL cover: RN pulsed low at clock 10 of a run -> all outputs reset the same cycle, no DONE pulse, new START yields a normal 24-clock run.
REQ-032 SHALL cover: START and ABORT high together in DONE -> IDLE, A=000, DONE=0; START held high during RUN -> run length unchanged.
REQ-033 SHALL cover, with SIG_EN defined: two back-to-back ideal runs give identical SIG; a single injected mismatch changes SIG; SIG=16'hFFFF after reset.
